// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the MM:SS countdown controller: state encodings,
// parameter defaults and the chain's wrap value.
package countdown_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRIME   = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    localparam int TICK_DIV_DEFAULT    = 100_000_000;
    localparam int ALARM_TICKS_DEFAULT = 10;

    // Value the digit chain shows right after PRIME wraps it from 00:00 (BCD MM:SS).
    localparam logic [15:0] CHAIN_MAX_BCD = 16'h5959;

    // The prescaler is parked at zero while the chain is idle or being primed.
    function automatic logic clears_prescaler(input state_t s);
        return (s == ST_IDLE) || (s == ST_PRIME);
    endfunction

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// Prescaler for the countdown tick: counts 0..DIV-1 while enabled and wraps.
// tick flags the last phase; phase is exported for the alarm blink.
module countdown_ctrl_tick_gen #(
    parameter int DIV = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    output logic                    tick,
    output logic [$clog2(DIV)-1:0]  phase
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    assign tick = (phase == LAST);

    // Advance the phase while enabled; clr wins and holds it at zero.
    always_ff @(posedge clk) begin
        if (clr)
            phase <= '0;
        else if (en)
            phase <= tick ? '0 : phase + W'(1);
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Sequencing controller for the MM:SS countdown digit chain: start/pause/clear,
// chain reset and count-enable, expiry detection and a blinking alarm.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int ALARM_TICKS = ALARM_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       all_zero,
    output logic       cnt_reset,
    output logic       cnt_ce,
    output logic       running,
    output logic       expired,
    output logic       alarm,
    output logic [2:0] state_dbg
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] HALF       = PW'(TICK_DIV / 2);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

    state_t          state;
    state_t          nxt;
    logic            tick;
    logic [PW-1:0]   phase;
    logic [AW-1:0]   alarm_cnt;
    logic            pre_clr;
    logic            pre_en;

    // Reset is folded into the prescaler clear so it restarts from zero.
    assign pre_clr = reset | clears_prescaler(state);
    assign pre_en  = (state == ST_RUN) | (state == ST_EXPIRED);

    countdown_ctrl_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick),
        .phase (phase)
    );

    // Next-state selection; clear is checked before anything else.
    always_comb begin
        nxt = state;
        if (btn_clear) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (btn_start) nxt = ST_PRIME;
                ST_PRIME:   nxt = ST_RUN;
                ST_RUN:     if (all_zero) nxt = ST_EXPIRED;
                            else if (btn_start) nxt = ST_PAUSE;
                ST_PAUSE:   if (btn_start) nxt = ST_RUN;
                ST_EXPIRED: if ((tick && alarm_cnt == ALARM_LAST) || btn_start) nxt = ST_IDLE;
                default:    nxt = ST_IDLE;
            endcase
        end
    end

    // State register with the state-decoded outputs registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt_reset <= 1'b1;
            running   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= nxt;
            cnt_reset <= (nxt == ST_IDLE);
            running   <= (nxt == ST_RUN);
            expired   <= (nxt == ST_EXPIRED);
        end
    end

    // Count alarm ticks only while expired; any other state clears it.
    always_ff @(posedge clk) begin
        if (reset || state != ST_EXPIRED)
            alarm_cnt <= '0;
        else if (tick)
            alarm_cnt <= alarm_cnt + AW'(1);
    end

    // PRIME wraps the chain to max; in RUN a zero chain suppresses the count so
    // it never wraps. Reset blocks a tick landing on the same edge.
    assign cnt_ce = ~reset & ((state == ST_PRIME) |
                              ((state == ST_RUN) & tick & ~all_zero));

    assign alarm     = (state == ST_EXPIRED) & (phase < HALF);
    assign state_dbg = state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with a behavioural MM:SS down-counting chain as load.
// Expected cnt_ce cycles are queued by each scenario and matched by a monitor.
module tb_countdown_ctrl;
    import countdown_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       btn_start;
    logic       btn_clear;
    logic       all_zero;
    logic       cnt_reset;
    logic       cnt_ce;
    logic       running;
    logic       expired;
    logic       alarm;
    logic [2:0] state_dbg;

    logic       force_zero;
    logic [3:0] s0, s1, m0, m1;
    logic [15:0] chain;

    int errors;
    int checks;
    int cyc;
    int exp_c;
    int exp_ce[$];

    countdown_ctrl #(.TICK_DIV(4), .ALARM_TICKS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .all_zero  (all_zero),
        .cnt_reset (cnt_reset),
        .cnt_ce    (cnt_ce),
        .running   (running),
        .expired   (expired),
        .alarm     (alarm),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mod10/mod06 down-counter chain: SS low, SS high, MM low, MM high
    always @(posedge clk) begin
        if (cnt_reset === 1'b1) begin
            {m1, m0, s1, s0} <= '0;
        end else if (cnt_ce === 1'b1) begin
            if (s0 != 0) s0 <= s0 - 4'd1;
            else begin
                s0 <= 4'd9;
                if (s1 != 0) s1 <= s1 - 4'd1;
                else begin
                    s1 <= 4'd5;
                    if (m0 != 0) m0 <= m0 - 4'd1;
                    else begin
                        m0 <= 4'd9;
                        m1 <= (m1 != 0) ? m1 - 4'd1 : 4'd5;
                    end
                end
            end
        end
    end
    assign chain    = {m1, m0, s1, s0};
    assign all_zero = force_zero | (chain == 16'h0000);

    // Scoreboard: every cnt_ce pulse must match the oldest expected cycle.
    always @(negedge clk) begin
        #3;
        if (cnt_ce === 1'b1) begin
            checks++;
            if (exp_ce.size() == 0) begin
                errors++;
                $display("FAIL cnt_ce_unexpected: pulse in cycle %0d, none expected", cyc);
            end else begin
                exp_c = exp_ce.pop_front();
                if (cyc !== exp_c) begin
                    errors++;
                    $display("FAIL cnt_ce_timing: pulse in cycle %0d, expected cycle %0d", cyc, exp_c);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; force_zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        checks++; if (cnt_reset !== 1'b1) begin errors++; $display("FAIL reset_cnt_reset: got %b want 1", cnt_reset); end
        checks++; if (cnt_ce !== 1'b0 || alarm !== 1'b0 || running !== 1'b0 || expired !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: ce=%b alarm=%b run=%b exp=%b want all 0", cnt_ce, alarm, running, expired);
        end
        checks++; if (chain !== 16'h0000) begin errors++; $display("FAIL reset_chain: got %h want 0000", chain); end
        reset = 1'b0;
    endtask

    task automatic test_start();
        int k;
        @(negedge clk); k = cyc; btn_start = 1'b1;
        exp_ce.push_back(k + 1); exp_ce.push_back(k + 5); exp_ce.push_back(k + 9);
        @(negedge clk); btn_start = 1'b0;
        checks++; if (state_dbg !== 3'd1 || cnt_reset !== 1'b0) begin
            errors++; $display("FAIL prime_state: state=%0d cnt_reset=%b want 1/0", state_dbg, cnt_reset);
        end
        @(negedge clk);
        checks++; if (chain !== CHAIN_MAX_BCD) begin errors++; $display("FAIL prime_wrap: chain=%h want %h", chain, CHAIN_MAX_BCD); end
        checks++; if (state_dbg !== 3'd2 || running !== 1'b1) begin
            errors++; $display("FAIL run_entry: state=%0d running=%b want 2/1", state_dbg, running);
        end
        repeat (4) @(negedge clk);
        checks++; if (chain !== 16'h5958) begin errors++; $display("FAIL first_tick: chain=%h want 5958", chain); end
        repeat (4) @(negedge clk);
        checks++; if (chain !== 16'h5957) begin errors++; $display("FAIL second_tick: chain=%h want 5957", chain); end
        checks++; if (exp_ce.size() != 0) begin errors++; $display("FAIL start_pending: %0d pulses missing, want 0", exp_ce.size()); end
    endtask

    // Entered with the prescaler at 0; the press lands at phase 1 so PAUSE holds phase 2.
    task automatic test_pause();
        int k;
        @(negedge clk); btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0;
        checks++; if (state_dbg !== 3'd3 || running !== 1'b0) begin
            errors++; $display("FAIL pause_entry: state=%0d running=%b want 3/0", state_dbg, running);
        end
        repeat (20) @(negedge clk);
        checks++; if (state_dbg !== 3'd3 || chain !== 16'h5957) begin
            errors++; $display("FAIL pause_hold: state=%0d chain=%h want 3/5957", state_dbg, chain);
        end
        k = cyc; btn_start = 1'b1; exp_ce.push_back(k + 2);
        @(negedge clk); btn_start = 1'b0;
        checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL resume_state: got %0d want 2", state_dbg); end
        repeat (2) @(negedge clk);
        checks++; if (chain !== 16'h5956) begin errors++; $display("FAIL resume_tick: chain=%h want 5956", chain); end
        checks++; if (exp_ce.size() != 0) begin errors++; $display("FAIL pause_pending: %0d pulses missing, want 0", exp_ce.size()); end
    endtask

    // Entered with prescaler 0 in RUN; zero is forced on the tick cycle.
    task automatic test_expiry();
        logic exp_a;
        repeat (3) @(negedge clk);
        force_zero = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_a = ((i % 4) < 2);
            checks++; if (expired !== 1'b1 || state_dbg !== 3'd4 || alarm !== exp_a) begin
                errors++; $display("FAIL expired_cycle%0d: exp=%b state=%0d alarm=%b want 1/4/%b", i, expired, state_dbg, alarm, exp_a);
            end
        end
        @(negedge clk);
        checks++; if (state_dbg !== 3'd0 || expired !== 1'b0 || alarm !== 1'b0 || cnt_reset !== 1'b1) begin
            errors++; $display("FAIL expiry_return: state=%0d exp=%b alarm=%b cnt_reset=%b want 0/0/0/1", state_dbg, expired, alarm, cnt_reset);
        end
        force_zero = 1'b0;
        @(negedge clk);
        checks++; if (chain !== 16'h0000) begin errors++; $display("FAIL expiry_chain: chain=%h want 0000", chain); end
    endtask

    task automatic test_ack();
        int k;
        @(negedge clk); k = cyc; btn_start = 1'b1; exp_ce.push_back(k + 1);
        @(negedge clk); btn_start = 1'b0; force_zero = 1'b1;
        @(negedge clk);
        checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL ack_run: state=%0d want 2", state_dbg); end
        @(negedge clk);
        checks++; if (state_dbg !== 3'd4 || expired !== 1'b1) begin
            errors++; $display("FAIL ack_expired: state=%0d exp=%b want 4/1", state_dbg, expired);
        end
        btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0; force_zero = 1'b0;
        checks++; if (state_dbg !== 3'd0 || cnt_reset !== 1'b1) begin
            errors++; $display("FAIL ack_idle: state=%0d cnt_reset=%b want 0/1", state_dbg, cnt_reset);
        end
        checks++; if (exp_ce.size() != 0) begin errors++; $display("FAIL ack_pending: %0d pulses missing, want 0", exp_ce.size()); end
    endtask

    task automatic test_clear();
        int k;
        @(negedge clk); k = cyc; btn_start = 1'b1; exp_ce.push_back(k + 1);
        @(negedge clk); btn_start = 1'b0;
        @(negedge clk);
        checks++; if (chain !== 16'h5959) begin errors++; $display("FAIL clear_primed: chain=%h want 5959", chain); end
        @(negedge clk); btn_start = 1'b1; btn_clear = 1'b1;
        @(negedge clk); btn_start = 1'b0; btn_clear = 1'b0;
        checks++; if (state_dbg !== 3'd0 || cnt_reset !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL clear_idle: state=%0d cnt_reset=%b run=%b want 0/1/0", state_dbg, cnt_reset, running);
        end
        @(negedge clk);
        checks++; if (chain !== 16'h0000) begin errors++; $display("FAIL clear_chain: chain=%h want 0000", chain); end
        checks++; if (exp_ce.size() != 0) begin errors++; $display("FAIL clear_pending: %0d pulses missing, want 0", exp_ce.size()); end
    endtask

    task automatic test_reset_mid();
        int k;
        @(negedge clk); k = cyc; btn_start = 1'b1; exp_ce.push_back(k + 1);
        @(negedge clk); btn_start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++; if (state_dbg !== 3'd0 || cnt_reset !== 1'b1 || alarm !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL midreset_state: state=%0d cnt_reset=%b alarm=%b run=%b want 0/1/0/0", state_dbg, cnt_reset, alarm, running);
        end
        checks++; if (chain !== 16'h5959) begin errors++; $display("FAIL midreset_no_ce: chain=%h want 5959", chain); end
        @(negedge clk);
        checks++; if (chain !== 16'h0000) begin errors++; $display("FAIL midreset_chain: chain=%h want 0000", chain); end
        k = cyc; btn_start = 1'b1; exp_ce.push_back(k + 1); exp_ce.push_back(k + 5);
        @(negedge clk); btn_start = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (chain !== 16'h5958) begin errors++; $display("FAIL midreset_restart: chain=%h want 5958", chain); end
        checks++; if (exp_ce.size() != 0) begin errors++; $display("FAIL midreset_pending: %0d pulses missing, want 0", exp_ce.size()); end
        btn_clear = 1'b1;
        @(negedge clk); btn_clear = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_start();
        test_pause();
        test_expiry();
        test_ack();
        test_clear();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
